rs_age_select: RTL and testbench
================================

Name: rs_age_select

Overview:
- Parametrised successor of the single-ALU reservation station.
- Holds DEPTH arithmetic/branch entries waiting for operands and snoops N_CDB result-broadcast channels.
- Dispatches the oldest ready entry to an external ALU over a valid/ready handshake; the ALU is no longer instantiated inside.
- Sits between Decoder (allocation), the CDB sources (ALU, LSB, future units) and the ALU; cleared by ROB flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ROB_W, 4, width of a ROB tag.
- N_CDB, 2, number of broadcast channels snooped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  ROB misprediction clear.
- rs_full  out  1  no free entry.
- in_valid  in  1  Decoder allocates an entry this cycle.
- in_op  in  3  funct3.
- in_type  in  7  opcode class.
- in_op_other  in  1  instr[30].
- in_pc  in  32  instruction address.
- in_v1, in_v2  in  32 each  operand values.
- in_dep1, in_dep2  in  1 each  operand still pending.
- in_tag1, in_tag2  in  ROB_W each  producer tags.
- in_rob_id  in  ROB_W  destination tag.
- cdb_valid  in  N_CDB  per-channel broadcast valid.
- cdb_rob_id  in  N_CDB*ROB_W  channel c at bits [c*ROB_W +: ROB_W].
- cdb_value  in  N_CDB*32  channel c at bits [c*32 +: 32].
- disp_valid  out  1  a ready entry is presented.
- disp_ready  in  1  ALU accepts.
- disp_op, disp_type, disp_op_other, disp_pc, disp_v1, disp_v2, disp_rob_id  out  as the in_* fields  selected entry.
- occupancy  out  $clog2(DEPTH)+1  valid entry count.

Behaviour:
- Reset (rst low at posedge, rdy ignored): all entries invalid, occupancy 0, age state cleared.
- After reset, rs_full=0 and disp_valid=0. disp_* data is don't-care while disp_valid=0; the bench checks 0 after reset.
- Priority at each posedge: reset > flush > !rdy (hold) > normal update.
- flush: all entries invalid and occupancy 0 next cycle; same-cycle in_valid and dispatch are discarded.
- rdy low:
  - no allocation, wakeup or free happens.
  - disp_valid is forced 0.
  - CDB broadcasts in that cycle are lost; producers must hold rdy semantics.
- rs_full = (occupancy == DEPTH), registered-derived, with no lookahead. in_valid while rs_full is ignored with no state change.
- Allocation:
  - takes the lowest-index free entry.
  - stores all fields and marks the entry youngest.
  - the entry becomes eligible for dispatch at the earliest the next cycle, never the same cycle unless the optional feature is enabled.
- Same-cycle capture at allocation: if in_depX and some channel has cdb_valid[c] with cdb_rob_id==in_tagX, the entry stores cdb_value with dep cleared. A wakeup is never lost.
- Wakeup: every valid entry with depX set and a tag match on any valid channel captures the value and clears depX at the posedge. The entry is eligible the following cycle.
- Multiple channels matching one tag in the same cycle: the lowest channel index wins.
- Ready entry: valid, !dep1 and !dep2.
- disp_valid = any ready entry. Selection is the strictly oldest ready entry by allocation order, combinational from registered state.
- Handshake:
  - on disp_valid && disp_ready the entry is freed at that posedge.
  - with disp_ready low, disp_valid and the presented entry stay stable unless an older entry becomes ready; an older ready entry pre-empts.
- Simultaneous allocate and dispatch: occupancy unchanged. The freed slot is not reusable in the same cycle.
- Age ordering survives arbitrary interleaving: it must not depend on entry index, and frees in the middle must not corrupt order.
- occupancy arithmetic: next = occ + alloc − disp, saturating is impossible by construction.

Optional Feature:
- RS_ISSUE_BYPASS_EN defined:
  - applies when in_valid is accepted, both operands are ready after same-cycle CDB capture, and no entry is ready.
  - the incoming instruction drives disp_* combinationally with disp_valid=1 in the same cycle.
  - if disp_ready=1 it is not allocated and occupancy is unchanged; otherwise it is allocated normally.
- Undefined: no combinational path from in_* to disp_*. Minimum alloc-to-dispatch latency is 1 cycle.

Test Plan:
- Reset: hold rst=0 2 cycles with in_valid=1 → occupancy=0, disp_valid=0, rs_full=0.
- Age order: allocate A(rob 3, dep1 on tag 7), then B(rob 4, ready), then C(rob 5, ready); broadcast tag 7 value 0x11 on channel 1 with disp_ready=0 → disp_rob_id=4 first; after A wakes, raising disp_ready dispatches 3, then 4, then 5.
- Allocation capture: in_dep2=1, in_tag2=9 with cdb channel 0 valid, tag 9, value 0xDEADBEEF in the same cycle → next cycle disp_v2=0xDEADBEEF, disp_valid=1.
- Full: fill DEPTH=8 entries all dependent → rs_full=1; a 9th in_valid is dropped with occupancy still 8; wake one and dispatch → occupancy 7, rs_full=0.
- Flush plus stall: flush=1 with in_valid=1 and disp_ready=1 → occupancy 0 next cycle, no dispatch handshake counted. With rdy=0 for 3 cycles → state is frozen and disp_valid=0.
- Bypass with RS_ISSUE_BYPASS_EN, empty RS: ready instruction with rob 2 and disp_ready=1 → disp_valid=1 and disp_rob_id=2 in the same cycle, occupancy stays 0. Without the macro, disp_valid rises one cycle later and occupancy pulses to 1.

Source files
------------

// File: rtl/rs_age_select.sv
// rs_age_select: oldest-first reservation station for a single external ALU.
// Holds DEPTH entries that wait for operands and snoops N_CDB result broadcast
// channels. The oldest ready entry is offered over a valid/ready handshake.
// An age matrix keeps allocation order independent of the entry index.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), flush (ROB clear)
//   in_*        Decoder allocation request and payload
//   cdb_*       N_CDB broadcast channels, channel c in slice c
//   disp_*      selected entry toward the ALU, disp_ready accepts it
//   rs_full     no free entry; occupancy is the valid entry count
//
// Optional build macro: RS_ISSUE_BYPASS_EN
//   When defined, an accepted instruction whose operands are ready (after
//   same-cycle CDB capture) is presented on disp_* in the same cycle if no
//   stored entry is ready. When undefined there is no in_* to disp_* path.
module rs_age_select #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned N_CDB = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    output logic                   rs_full,
    input  logic                   in_valid,
    input  logic [2:0]             in_op,
    input  logic [6:0]             in_type,
    input  logic                   in_op_other,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_v1,
    input  logic [31:0]            in_v2,
    input  logic                   in_dep1,
    input  logic                   in_dep2,
    input  logic [ROB_W-1:0]       in_tag1,
    input  logic [ROB_W-1:0]       in_tag2,
    input  logic [ROB_W-1:0]       in_rob_id,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*ROB_W-1:0] cdb_rob_id,
    input  logic [N_CDB*32-1:0]    cdb_value,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [2:0]             disp_op,
    output logic [6:0]             disp_type,
    output logic                   disp_op_other,
    output logic [31:0]            disp_pc,
    output logic [31:0]            disp_v1,
    output logic [31:0]            disp_v2,
    output logic [ROB_W-1:0]       disp_rob_id,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [6:0]       typ;
        logic             op_other;
        logic [31:0]      pc;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic             dep1;
        logic             dep2;
        logic [ROB_W-1:0] tag1;
        logic [ROB_W-1:0] tag2;
        logic [ROB_W-1:0] rob_id;
    } entry_t;

    // Returns {hit, value}; scanning downward lets the lowest channel win.
    function automatic logic [32:0] cdb_lookup(
        input logic [ROB_W-1:0]       tag,
        input logic [N_CDB-1:0]       vld,
        input logic [N_CDB*ROB_W-1:0] ids,
        input logic [N_CDB*32-1:0]    vals
    );
        logic [32:0] res;
        res = '0;
        for (int c = N_CDB - 1; c >= 0; c--) begin
            if (vld[c] && (ids[c*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, vals[c*32 +: 32]};
            end
        end
        return res;
    endfunction

    // older_q[i][j] set means entry i was allocated before entry j.
    entry_t             ent_q   [DEPTH];
    entry_t             ent_d   [DEPTH];
    logic [DEPTH-1:0]   older_q [DEPTH];
    logic [DEPTH-1:0]   older_d [DEPTH];
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;

    logic [DEPTH-1:0]   wk_hit1;
    logic [DEPTH-1:0]   wk_hit2;
    logic [31:0]        wk_val1 [DEPTH];
    logic [31:0]        wk_val2 [DEPTH];
    logic [DEPTH-1:0]   ready_vec;
    logic [DEPTH-1:0]   sel_oh;
    logic               any_ready;
    entry_t             sel_ent;
    entry_t             in_ent;
    entry_t             out_ent;
    logic [IDX_W-1:0]   free_idx;
    logic               q_fire;
    logic               alloc_c;

    // Wakeup lookup for every stored operand.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wk_hit1[i], wk_val1[i]} = cdb_lookup(ent_q[i].tag1, cdb_valid, cdb_rob_id, cdb_value);
            {wk_hit2[i], wk_val2[i]} = cdb_lookup(ent_q[i].tag2, cdb_valid, cdb_rob_id, cdb_value);
        end
    end

    // Incoming entry with same-cycle broadcast capture applied.
    always_comb begin
        logic [32:0] c1;
        logic [32:0] c2;
        c1              = cdb_lookup(in_tag1, cdb_valid, cdb_rob_id, cdb_value);
        c2              = cdb_lookup(in_tag2, cdb_valid, cdb_rob_id, cdb_value);
        in_ent          = '0;
        in_ent.valid    = 1'b1;
        in_ent.op       = in_op;
        in_ent.typ      = in_type;
        in_ent.op_other = in_op_other;
        in_ent.pc       = in_pc;
        in_ent.tag1     = in_tag1;
        in_ent.tag2     = in_tag2;
        in_ent.rob_id   = in_rob_id;
        in_ent.dep1     = in_dep1 && !c1[32];
        in_ent.dep2     = in_dep2 && !c2[32];
        in_ent.v1       = (in_dep1 && c1[32]) ? c1[31:0] : in_v1;
        in_ent.v2       = (in_dep2 && c2[32]) ? c2[31:0] : in_v2;
    end

    // Oldest ready entry: ready and no other ready entry is older.
    always_comb begin
        ready_vec = '0;
        sel_oh    = '0;
        sel_ent   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = ent_q[i].valid && !ent_q[i].dep1 && !ent_q[i].dep2;
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ready_vec[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready_vec[j] && older_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_ent = entry_t'(sel_ent | ent_q[i]);
            end
        end
        any_ready = |ready_vec;
    end

    // Lowest-index free slot; only consumed when not full.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign rs_full   = (occ_q == OCC_W'(DEPTH));
    assign occupancy = occ_q;
    assign q_fire    = rdy && any_ready && disp_ready;

`ifdef RS_ISSUE_BYPASS_EN
    logic byp_c;
    assign byp_c      = rst && rdy && !flush && in_valid && !rs_full &&
                        !in_ent.dep1 && !in_ent.dep2 && !any_ready;
    assign out_ent    = byp_c ? in_ent : sel_ent;
    assign disp_valid = (rdy && any_ready) || byp_c;
    // A bypassed instruction that is taken never occupies a slot.
    assign alloc_c    = rdy && !flush && in_valid && !rs_full && !(byp_c && disp_ready);
`else
    assign out_ent    = sel_ent;
    assign disp_valid = rdy && any_ready;
    assign alloc_c    = rdy && !flush && in_valid && !rs_full;
`endif

    assign disp_op       = out_ent.op;
    assign disp_type     = out_ent.typ;
    assign disp_op_other = out_ent.op_other;
    assign disp_pc       = out_ent.pc;
    assign disp_v1       = out_ent.v1;
    assign disp_v2       = out_ent.v2;
    assign disp_rob_id   = out_ent.rob_id;

    // Next state: flush beats hold, hold beats wakeup/free/allocate.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]   = ent_q[i];
            older_d[i] = older_q[i];
        end
        occ_d = occ_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            occ_d = '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid && ent_q[i].dep1 && wk_hit1[i]) begin
                    ent_d[i].v1   = wk_val1[i];
                    ent_d[i].dep1 = 1'b0;
                end
                if (ent_q[i].valid && ent_q[i].dep2 && wk_hit2[i]) begin
                    ent_d[i].v2   = wk_val2[i];
                    ent_d[i].dep2 = 1'b0;
                end
                if (q_fire && sel_oh[i]) begin
                    ent_d[i].valid = 1'b0;
                end
            end
            // New entry is younger than everything else present.
            if (alloc_c) begin
                ent_d[free_idx]   = in_ent;
                older_d[free_idx] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(free_idx)) begin
                        older_d[j][free_idx] = 1'b1;
                    end
                end
            end
            occ_d = occ_q + OCC_W'(alloc_c) - OCC_W'(q_fire);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= ent_d[i];
                older_q[i] <= older_d[i];
            end
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_rs_age_select.sv
// tb_rs_age_select: directed self-checking bench for rs_age_select
// (DEPTH=8, ROB_W=4, N_CDB=2). Inputs change 1 time unit after posedge;
// outputs are sampled in the same window, away from the active edge.
module tb_rs_age_select;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        rs_full;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [6:0]  in_type;
    logic        in_op_other;
    logic [31:0] in_pc;
    logic [31:0] in_v1;
    logic [31:0] in_v2;
    logic        in_dep1;
    logic        in_dep2;
    logic [3:0]  in_tag1;
    logic [3:0]  in_tag2;
    logic [3:0]  in_rob_id;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        disp_valid;
    logic        disp_ready;
    logic [2:0]  disp_op;
    logic [6:0]  disp_type;
    logic        disp_op_other;
    logic [31:0] disp_pc;
    logic [31:0] disp_v1;
    logic [31:0] disp_v2;
    logic [3:0]  disp_rob_id;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    rs_age_select #(.DEPTH(8), .ROB_W(4), .N_CDB(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rs_full(rs_full),
        .in_valid(in_valid), .in_op(in_op), .in_type(in_type),
        .in_op_other(in_op_other), .in_pc(in_pc), .in_v1(in_v1), .in_v2(in_v2),
        .in_dep1(in_dep1), .in_dep2(in_dep2), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_rob_id(in_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_type(disp_type), .disp_op_other(disp_op_other),
        .disp_pc(disp_pc), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_rob_id(disp_rob_id), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rob, input logic d1, input logic [3:0] t1,
                          input logic [31:0] v1, input logic d2, input logic [3:0] t2,
                          input logic [31:0] v2);
        in_valid    = 1'b1;
        in_rob_id   = rob;
        in_dep1     = d1;
        in_tag1     = t1;
        in_v1       = v1;
        in_dep2     = d2;
        in_tag2     = t2;
        in_v2       = v2;
        in_op       = rob[2:0];
        in_type     = 7'h33;
        in_op_other = rob[0];
        in_pc       = 32'h1000 + 32'(rob);
    endtask

    task automatic alloc(input logic [3:0] rob, input logic d1, input logic [3:0] t1,
                         input logic [31:0] v1, input logic d2, input logic [3:0] t2,
                         input logic [31:0] v2);
        set_in(rob, d1, t1, v1, d2, t2, v2);
        step();
        in_valid = 1'b0;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[ch]           = 1'b1;
        cdb_rob_id[ch*4 +: 4]   = tag;
        cdb_value[ch*32 +: 32]  = val;
    endtask

    task automatic clr_cdb();
        cdb_valid  = '0;
        cdb_rob_id = '0;
        cdb_value  = '0;
    endtask

    initial begin
        rst        = 1'b0;
        rdy        = 1'b1;
        flush      = 1'b0;
        disp_ready = 1'b0;
        clr_cdb();
        set_in(4'd1, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2);

        // Reset held two cycles with an allocation request present.
        step();
        step();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_disp_rob", 32'(disp_rob_id), 32'd0);
        chk("rst_disp_v1", disp_v1, 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        chk("post_rst_valid", 32'(disp_valid), 32'd0);

        // Age order: A waits on tag 7, B and C ready.
        alloc(4'd3, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'h5);
        chk("age_a_occ", 32'(occupancy), 32'd1);
        chk("age_a_valid", 32'(disp_valid), 32'd0);
        alloc(4'd4, 1'b0, 4'd0, 32'h40, 1'b0, 4'd0, 32'h41);
        chk("age_b_valid", 32'(disp_valid), 32'd1);
        chk("age_b_rob", 32'(disp_rob_id), 32'd4);
        alloc(4'd5, 1'b0, 4'd0, 32'h50, 1'b0, 4'd0, 32'h51);
        chk("age_c_occ", 32'(occupancy), 32'd3);
        set_cdb(1, 4'd7, 32'h11);
        #1;
        chk("age_first_rob", 32'(disp_rob_id), 32'd4);
        step();
        clr_cdb();
        chk("age_wake_rob", 32'(disp_rob_id), 32'd3);
        chk("age_wake_v1", disp_v1, 32'h11);
        chk("age_wake_v2", disp_v2, 32'h5);
        chk("age_wake_pc", disp_pc, 32'h1003);
        chk("age_wake_type", 32'(disp_type), 32'h33);
        disp_ready = 1'b1;
        step();
        chk("age_d1_rob", 32'(disp_rob_id), 32'd4);
        chk("age_d1_occ", 32'(occupancy), 32'd2);
        step();
        chk("age_d2_rob", 32'(disp_rob_id), 32'd5);
        chk("age_d2_occ", 32'(occupancy), 32'd1);
        step();
        chk("age_d3_valid", 32'(disp_valid), 32'd0);
        chk("age_d3_occ", 32'(occupancy), 32'd0);
        disp_ready = 1'b0;

        // Two channels hit the same tag: channel 0 wins.
        alloc(4'd6, 1'b1, 4'd8, 32'h0, 1'b0, 4'd0, 32'h6);
        set_cdb(0, 4'd8, 32'hAAAA);
        set_cdb(1, 4'd8, 32'hBBBB);
        step();
        clr_cdb();
        chk("prio_rob", 32'(disp_rob_id), 32'd6);
        chk("prio_v1", disp_v1, 32'hAAAA);
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        chk("prio_occ", 32'(occupancy), 32'd0);

        // Capture of a broadcast in the allocation cycle.
        set_in(4'd1, 1'b0, 4'd0, 32'h1, 1'b1, 4'd9, 32'h0);
        set_cdb(0, 4'd9, 32'hDEADBEEF);
        step();
        in_valid = 1'b0;
        clr_cdb();
        chk("cap_valid", 32'(disp_valid), 32'd1);
        chk("cap_v2", disp_v2, 32'hDEADBEEF);
        chk("cap_rob", 32'(disp_rob_id), 32'd1);
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        chk("cap_occ", 32'(occupancy), 32'd0);

        // Fill all eight entries, each waiting on tag rob+8.
        for (int k = 0; k < 8; k++) begin
            alloc(4'(k), 1'b1, 4'(k + 8), 32'h0, 1'b0, 4'd0, 32'(k));
        end
        chk("full_flag", 32'(rs_full), 32'd1);
        chk("full_occ", 32'(occupancy), 32'd8);
        chk("full_valid", 32'(disp_valid), 32'd0);
        alloc(4'd9, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'h9);
        chk("full_drop_occ", 32'(occupancy), 32'd8);
        chk("full_drop_valid", 32'(disp_valid), 32'd0);
        set_cdb(0, 4'd13, 32'h55);
        step();
        clr_cdb();
        chk("full_wake_rob", 32'(disp_rob_id), 32'd5);
        chk("full_wake_v1", disp_v1, 32'h55);
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        chk("full_free_occ", 32'(occupancy), 32'd7);
        chk("full_free_flag", 32'(rs_full), 32'd0);

        // Reused middle slot must still rank youngest.
        alloc(4'd14, 1'b0, 4'd0, 32'hE, 1'b0, 4'd0, 32'hE);
        chk("reuse_rob", 32'(disp_rob_id), 32'd14);
        chk("reuse_occ", 32'(occupancy), 32'd8);
        set_cdb(1, 4'd8, 32'h80);
        step();
        clr_cdb();
        chk("preempt_rob", 32'(disp_rob_id), 32'd0);
        chk("preempt_v1", disp_v1, 32'h80);

        // Flush discards same-cycle allocation and dispatch.
        flush      = 1'b1;
        disp_ready = 1'b1;
        set_in(4'd3, 1'b0, 4'd0, 32'h3, 1'b0, 4'd0, 32'h3);
        step();
        flush      = 1'b0;
        disp_ready = 1'b0;
        in_valid   = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(disp_valid), 32'd0);
        chk("flush_full", 32'(rs_full), 32'd0);

        // Stall: rdy low freezes state and loses broadcasts.
        alloc(4'd2, 1'b1, 4'd4, 32'h0, 1'b0, 4'd0, 32'h2);
        alloc(4'd6, 1'b0, 4'd0, 32'h6, 1'b0, 4'd0, 32'h6);
        chk("stall_pre_rob", 32'(disp_rob_id), 32'd6);
        rdy        = 1'b0;
        disp_ready = 1'b1;
        set_in(4'd7, 1'b0, 4'd0, 32'h7, 1'b0, 4'd0, 32'h7);
        set_cdb(0, 4'd4, 32'h44);
        #1;
        chk("stall_valid_now", 32'(disp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_occ", 32'(occupancy), 32'd2);
            chk("stall_valid", 32'(disp_valid), 32'd0);
        end
        rdy        = 1'b1;
        disp_ready = 1'b0;
        in_valid   = 1'b0;
        clr_cdb();
        #1;
        chk("resume_valid", 32'(disp_valid), 32'd1);
        chk("resume_rob", 32'(disp_rob_id), 32'd6);
        step();
        chk("resume_hold_rob", 32'(disp_rob_id), 32'd6);
        chk("resume_occ", 32'(occupancy), 32'd2);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("clear_occ", 32'(occupancy), 32'd0);

        // Ready instruction into an empty station with disp_ready high.
        disp_ready = 1'b1;
        set_in(4'd2, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 32'h23);
        #1;
`ifdef RS_ISSUE_BYPASS_EN
        chk("byp_valid", 32'(disp_valid), 32'd1);
        chk("byp_rob", 32'(disp_rob_id), 32'd2);
        step();
        in_valid = 1'b0;
        chk("byp_occ", 32'(occupancy), 32'd0);
`else
        chk("nobyp_valid", 32'(disp_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("nobyp_occ", 32'(occupancy), 32'd1);
        chk("nobyp_valid_late", 32'(disp_valid), 32'd1);
        chk("nobyp_rob", 32'(disp_rob_id), 32'd2);
        step();
        chk("nobyp_occ_end", 32'(occupancy), 32'd0);
`endif
        disp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
